// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: sequential word-addressed PC advance, two-source redirect
// arbitration (late mispredict over early JAL), epoch tagging and a saturating redirect counter.
module fetch_pc_gen #(
    parameter int               WIDTH    = 31,
    parameter int               EPOCH_W  = 2,
    parameter logic [WIDTH:0]   RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jump,
    input  logic [WIDTH:0]     targetAddress,
    input  logic [EPOCH_W-1:0] jalEpoch,
    input  logic               mispredict,
    input  logic [WIDTH:0]     correctPC,
    input  logic               stall,
    output logic [WIDTH:0]     fetchPC,
    output logic               fetchValid,
    output logic [EPOCH_W-1:0] fetchEpoch,
    output logic               redirectTaken,
    output logic [CNT_W-1:0]   redirectCount
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        BUBBLE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               redirectAccept;
    logic [WIDTH:0]     redirectPC;

    // A JAL whose epoch no longer matches was fetched down a path that has since been
    // abandoned, so it must not steer fetch; a mispredict is always authoritative.
    always_comb begin
        redirectAccept = 1'b0;
        redirectPC     = targetAddress;
        if (mispredict) begin
            redirectAccept = 1'b1;
            redirectPC     = correctPC;
        end else if (jump && (jalEpoch == epoch_q)) begin
            redirectAccept = 1'b1;
            redirectPC     = targetAddress;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        epoch_d = epoch_q;
        count_d = count_q;
        if (redirectAccept) begin
            state_d = BUBBLE;
            pc_d    = redirectPC;
            valid_d = 1'b0;
            epoch_d = epoch_q + 1'b1;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
                RUN: begin
                    valid_d = 1'b1;
                    if (!stall) begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                BUBBLE: begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
                default: begin
                    state_d = BOOT;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            epoch_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            epoch_q <= epoch_d;
            count_q <= count_d;
        end
    end

    // The pulse is combinational, so it is masked by reset to keep every output at its reset value.
    assign redirectTaken = redirectAccept & ~reset;
    assign fetchPC       = pc_q;
    assign fetchValid    = valid_q;
    assign fetchEpoch    = epoch_q;
    assign redirectCount = count_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: a default instance for boot, redirect, stall and reset
// behaviour, plus an all-ones RESET_PC / 2-bit counter instance for wrap and saturation.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        jump;
    logic [31:0] targetAddress;
    logic [1:0]  jalEpoch;
    logic        mispredict;
    logic [31:0] correctPC;
    logic        stall;
    logic [31:0] fetchPC;
    logic        fetchValid;
    logic [1:0]  fetchEpoch;
    logic        redirectTaken;
    logic [15:0] redirectCount;

    logic        jump2;
    logic [31:0] targetAddress2;
    logic [1:0]  jalEpoch2;
    logic        mispredict2;
    logic [31:0] correctPC2;
    logic [31:0] fetchPC2;
    logic        fetchValid2;
    logic [1:0]  fetchEpoch2;
    logic        redirectTaken2;
    logic [1:0]  redirectCount2;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    fetch_pc_gen dut (
        .clk(clk), .reset(reset), .jump(jump), .targetAddress(targetAddress),
        .jalEpoch(jalEpoch), .mispredict(mispredict), .correctPC(correctPC),
        .stall(stall), .fetchPC(fetchPC), .fetchValid(fetchValid),
        .fetchEpoch(fetchEpoch), .redirectTaken(redirectTaken),
        .redirectCount(redirectCount)
    );

    fetch_pc_gen #(.WIDTH(31), .EPOCH_W(2), .RESET_PC(32'hFFFF_FFFF), .CNT_W(2)) dutSat (
        .clk(clk), .reset(reset), .jump(jump2), .targetAddress(targetAddress2),
        .jalEpoch(jalEpoch2), .mispredict(mispredict2), .correctPC(correctPC2),
        .stall(stall), .fetchPC(fetchPC2), .fetchValid(fetchValid2),
        .fetchEpoch(fetchEpoch2), .redirectTaken(redirectTaken2),
        .redirectCount(redirectCount2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic j, input logic [31:0] tgt, input logic [1:0] je,
                                 input logic mp, input logic [31:0] cpc, input logic st);
        jump          = j;
        targetAddress = tgt;
        jalEpoch      = je;
        mispredict    = mp;
        correctPC     = cpc;
        stall         = st;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] pc, input logic v,
                              input logic [1:0] ep, input logic [15:0] cnt);
        checkOutput({tag, ".pc"}, 64'(fetchPC), 64'(pc));
        checkOutput({tag, ".valid"}, 64'(fetchValid), 64'(v));
        checkOutput({tag, ".epoch"}, 64'(fetchEpoch), 64'(ep));
        checkOutput({tag, ".count"}, 64'(redirectCount), 64'(cnt));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        jump2 = 1'b0; targetAddress2 = '0; jalEpoch2 = '0; mispredict2 = 1'b0; correctPC2 = '0;
        #7;
        checkFetch("reset", 32'h0, 1'b0, 2'd0, 16'd0);
        checkOutput("reset.taken", 64'(redirectTaken), 64'd0);
        checkOutput("resetSat.pc", 64'(fetchPC2), 64'hFFFF_FFFF);

        reset = 1'b0;
        #1;
        checkFetch("boot", 32'h0, 1'b0, 2'd0, 16'd0);
        tick;
        checkFetch("firstFetch", 32'h0, 1'b1, 2'd0, 16'd0);
        checkOutput("sat.firstPc", 64'(fetchPC2), 64'hFFFF_FFFF);
        checkOutput("sat.firstValid", 64'(fetchValid2), 64'd1);
        tick;
        checkFetch("seq1", 32'h1, 1'b1, 2'd0, 16'd0);
        checkOutput("sat.wrapPc", 64'(fetchPC2), 64'h0);

        // Saturation instance: five consecutive mispredicts while the main instance runs on.
        mispredict2 = 1'b1;
        correctPC2  = 32'h20;
        tick;
        checkFetch("seq2", 32'h2, 1'b1, 2'd0, 16'd0);
        tick;
        checkFetch("seq3", 32'h3, 1'b1, 2'd0, 16'd0);
        checkOutput("sat.count2", 64'(redirectCount2), 64'd2);
        tick;
        tick;
        checkFetch("seq5", 32'h5, 1'b1, 2'd0, 16'd0);

        applyStimulus(1'b1, 32'h40, 2'd0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("jal.taken", 64'(redirectTaken), 64'd1);
        tick;
        mispredict2 = 1'b0;
        checkOutput("sat.countSat", 64'(redirectCount2), 64'd3);
        checkOutput("sat.epoch", 64'(fetchEpoch2), 64'd1);
        checkOutput("sat.pc", 64'(fetchPC2), 64'h20);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        checkFetch("jal.bubble", 32'h40, 1'b0, 2'd1, 16'd1);
        tick;
        checkFetch("jal.valid", 32'h40, 1'b1, 2'd1, 16'd1);
        tick;
        checkFetch("jal.next", 32'h41, 1'b1, 2'd1, 16'd1);

        applyStimulus(1'b1, 32'h80, 2'd0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput("stale.taken", 64'(redirectTaken), 64'd0);
        tick;
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        checkFetch("stale", 32'h42, 1'b1, 2'd1, 16'd1);

        applyStimulus(1'b1, 32'h40, 2'd1, 1'b1, 32'h100, 1'b0);
        #1;
        checkOutput("prio.taken", 64'(redirectTaken), 64'd1);
        tick;
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        checkFetch("prio", 32'h100, 1'b0, 2'd2, 16'd2);
        tick;
        checkFetch("prio.valid", 32'h100, 1'b1, 2'd2, 16'd2);

        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h10, 1'b0);
        tick;
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        tick;
        checkFetch("at10", 32'h10, 1'b1, 2'd3, 16'd3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checkFetch($sformatf("stall%0d", i), 32'h10, 1'b1, 2'd3, 16'd3);
        end

        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h200, 1'b1);
        #1;
        checkOutput("stallRedir.taken", 64'(redirectTaken), 64'd1);
        tick;
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1);
        checkFetch("stallRedir", 32'h200, 1'b0, 2'd0, 16'd4);
        tick;
        checkFetch("stallBubbleEnd", 32'h200, 1'b1, 2'd0, 16'd4);
        tick;
        checkFetch("stallHold", 32'h200, 1'b1, 2'd0, 16'd4);
        stall = 1'b0;
        tick;
        checkFetch("stallResume", 32'h201, 1'b1, 2'd0, 16'd4);

        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h300, 1'b0);
        tick;
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h400, 1'b0);
        tick;
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        checkFetch("b2b", 32'h400, 1'b0, 2'd2, 16'd6);
        tick;
        checkFetch("b2b.valid", 32'h400, 1'b1, 2'd2, 16'd6);

        applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h500, 1'b0);
        tick;
        checkFetch("preReset", 32'h500, 1'b0, 2'd3, 16'd7);
        reset = 1'b1;
        #1;
        checkFetch("asyncReset", 32'h0, 1'b0, 2'd0, 16'd0);
        checkOutput("asyncReset.taken", 64'(redirectTaken), 64'd0);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage PC generator and redirect arbiter, the receiving end of the front-end redirect path. Holds the architectural fetch PC, advances it sequentially (word-addressed, +1 per instruction), and accepts redirects from two sources: the early JAL target from the branch target resolver two cycles after rename, and the late mispredict correction from branch execution. Tags every fetched PC with an epoch so downstream stages can drop wrong-path instructions already in flight, and counts accepted redirects for performance monitoring.

## Interface

- WIDTH, 31, MSB index of PC/address buses (bus width WIDTH+1)
- EPOCH_W, 2, width of the fetch epoch tag
- RESET_PC, 0, fetch PC loaded on reset
- CNT_W, 16, width of redirect performance counter

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- jump  in  1  early JAL redirect request from target resolver
- targetAddress  in  WIDTH+1  JAL target, valid when jump=1
- jalEpoch  in  EPOCH_W  epoch tag carried by the requesting JAL
- mispredict  in  1  late redirect from branch execution
- correctPC  in  WIDTH+1  corrected PC, valid when mispredict=1
- stall  in  1  instruction memory/decode not ready; fetch holds
- fetchPC  out  WIDTH+1  PC presented to instruction memory
- fetchValid  out  1  fetchPC is a real fetch request
- fetchEpoch  out  EPOCH_W  epoch tag of fetchPC
- redirectTaken  out  1  pulse: a redirect was accepted this cycle
- redirectCount  out  CNT_W  saturating count of accepted redirects

## Operation

- States: BOOT, RUN, BUBBLE. Reset -> BOOT.
- Reset values: fetchPC=RESET_PC, fetchValid=0, fetchEpoch=0, redirectTaken=0, redirectCount=0.
- BOOT: fetchValid=0; next cycle -> RUN, fetchPC unchanged.
- RUN: fetchValid=1. If no redirect accepted and stall=0: fetchPC <= fetchPC+1. If stall=1: fetchPC, fetchEpoch held stable.
- BUBBLE: fetchValid=0; next cycle -> RUN with fetchPC unchanged (the redirect target).
- Redirect acceptance (evaluated in every state, including BOOT):
  - mispredict=1: always accepted; new PC = correctPC. Highest priority.
  - else jump=1 and jalEpoch==fetchEpoch: accepted; new PC = targetAddress.
  - else jump=1 with stale jalEpoch: ignored (wrong-path JAL), no side effects.
- On accepted redirect: fetchPC <= new PC, fetchEpoch <= fetchEpoch+1 (mod 2^EPOCH_W), state <= BUBBLE, redirectTaken=1 (combinational, same cycle as request), redirectCount <= redirectCount+1, saturating at 2^CNT_W-1.
- Redirects override stall: stall never blocks or delays a redirect.
- Simultaneous jump and mispredict: mispredict wins, jump dropped, epoch increments once.
- PC arithmetic: unsigned WIDTH+1 bits, fetchPC+1 wraps from all-ones to 0.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; pending redirect discarded.

## Timing

- Sequential advance: fetchPC at cycle t+1 = fetchPC(t)+1 when RUN, stall=0, no redirect.
- Redirect latency: request at cycle t -> fetchPC=target, fetchValid=0, fetchEpoch incremented at t+1; fetchValid=1 with same PC at t+2; target+1 at t+3 if stall=0.
- Back-to-back redirects (t and t+1): second wins, stays in BUBBLE, epoch incremented twice, count +2.
- Stall in RUN: outputs held for every stalled cycle; fetch resumes the cycle after stall falls.
- Stall during BUBBLE: BUBBLE still lasts exactly one cycle; RUN then holds PC while stall=1.
- First valid fetch after reset release: cycle 2 (BOOT occupies cycle 1), fetchPC=RESET_PC.

## Test plan

- Reset/boot: release reset, stall=0 -> fetchValid 0 then 1 at PC 0, then PCs 1,2,3; epoch 0, count 0.
- JAL redirect: at PC 5, jump=1, targetAddress=0x40, jalEpoch=0 -> redirectTaken=1; next cycle PC 0x40, valid=0, epoch 1; then valid=1 at 0x40, then 0x41.
- Stale JAL: epoch=1, jump=1 with jalEpoch=0, target 0x80 -> ignored; PC continues +1, count unchanged.
- Priority: jump (target 0x40, matching epoch) and mispredict (correctPC 0x100) same cycle -> PC 0x100, epoch +1 only, count +1.
- Stall interaction: stall=1 for 3 cycles at PC 0x10 -> PC held; mispredict to 0x200 during stall -> BUBBLE, then PC 0x200 held until stall=0.
- Wrap and saturation: RESET_PC=0xFFFFFFFF -> next PC 0; CNT_W=2 with 5 redirects -> redirectCount stays 3; async reset mid-BUBBLE -> outputs return to reset values immediately.
